y86_pc_status: RTL and testbench

Program-counter and processor-status controller for the sequential Y86-64 core. Owns the PC register, samples the fetch exception flags (hlt, in_mem, in_inst) each instruction, latches the architectural status code (AOK/HLT/ADR/INS) and stops the machine on the first non-AOK condition. It generalises the PC/status logic with:

- a parametrised address width and reset vector;
- run and single-step modes;
- retired-instruction and cycle counters;
- an instruction-limit watchdog.

It sits between pc_update (source of new_pc) and fetch (consumer of pc).

---
 rtl/y86_pkg.sv | 61 ++++++
 rtl/y86_pc_status_if.sv | 36 +++
 rtl/y86_stat_enc.sv | 42 ++++
 rtl/y86_pc_status.sv | 178 +++++++++++++++++
 tb/tb_y86_pc_status.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the sequential Y86-64 core:
//   - architectural status codes (AOK/HLT/ADR/INS) and their one-hot form
//   - PC/status controller state encoding
//   - instruction codes used by fetch and decode
// No ports; imported with "import y86_pkg::*".
// ---------------------------------------------------------------------------
package y86_pkg;

    // Architectural status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // PC/status controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_STOP      = 2'd3
    } ctrl_state_e;

    // One-hot view of the status code
    typedef struct packed {
        logic aok;
        logic halt;
        logic adr;
        logic ins;
    } stat_onehot_t;

    // Status code to one-hot decode; an unused code decodes to all zeros
    function automatic stat_onehot_t stat_decode(input logic [2:0] st);
        stat_onehot_t oh;
        oh = '{aok: 1'b0, halt: 1'b0, adr: 1'b0, ins: 1'b0};
        case (st)
            STAT_AOK: oh.aok  = 1'b1;
            STAT_HLT: oh.halt = 1'b1;
            STAT_ADR: oh.adr  = 1'b1;
            STAT_INS: oh.ins  = 1'b1;
            default:  oh      = '{aok: 1'b0, halt: 1'b0, adr: 1'b0, ins: 1'b0};
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/y86_pc_status_if.sv
// ---------------------------------------------------------------------------
// y86_pc_status_if
// Bus between the PC/status controller and its neighbours in the core.
//   new_pc          : next PC from pc_update
//   hlt/in_mem/in_inst : exception flags from fetch
//   pc              : current PC to fetch
//   commit          : instruction retires this cycle
//   status, aok/halt/adr/ins : architectural status and its one-hot decode
// Modports: master = the core side (drives new_pc and flags),
//           slave  = the controller (drives pc, commit, status).
// ---------------------------------------------------------------------------
interface y86_pc_status_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] new_pc;
    logic              hlt;
    logic              in_mem;
    logic              in_inst;
    logic [ADDR_W-1:0] pc;
    logic              commit;
    logic [2:0]        status;
    logic              aok;
    logic              halt;
    logic              adr;
    logic              ins;

    modport master (
        output new_pc, hlt, in_mem, in_inst,
        input  pc, commit, status, aok, halt, adr, ins
    );

    modport slave (
        input  new_pc, hlt, in_mem, in_inst,
        output pc, commit, status, aok, halt, adr, ins
    );
endinterface

// File: rtl/y86_stat_enc.sv
// ---------------------------------------------------------------------------
// y86_stat_enc
// Combinational priority encoder for the fetch exception flags.
// Priority: hlt > in_mem > in_inst; no flag gives AOK.
// Ports:
//   hlt_i, in_mem_i, in_inst_i : fetch flags
//   exc_o     : any flag set
//   status_o  : 3-bit status code
//   onehot_o  : one-hot decode of status_o
// ---------------------------------------------------------------------------
module y86_stat_enc
    import y86_pkg::*;
(
    input  logic         hlt_i,
    input  logic         in_mem_i,
    input  logic         in_inst_i,
    output logic         exc_o,
    output logic [2:0]   status_o,
    output stat_onehot_t onehot_o
);

    logic [2:0] status_s;

    // Priority selection of the status code
    always_comb begin
        status_s = STAT_AOK;
        if (hlt_i) begin
            status_s = STAT_HLT;
        end else if (in_mem_i) begin
            status_s = STAT_ADR;
        end else if (in_inst_i) begin
            status_s = STAT_INS;
        end else begin
            status_s = STAT_AOK;
        end
    end

    assign exc_o    = hlt_i | in_mem_i | in_inst_i;
    assign status_o = status_s;
    assign onehot_o = stat_decode(status_s);

endmodule

// File: rtl/y86_pc_status.sv
// ---------------------------------------------------------------------------
// y86_pc_status
// Program-counter and processor-status controller for the sequential
// Y86-64 core. Holds the PC, retires one instruction per cycle (free run)
// or per step pulse (single-step), latches the first non-AOK status and
// stops. Optional instruction-limit watchdog.
// Parameters:
//   ADDR_W    : PC width
//   RESET_PC  : PC after reset / clear
//   CNT_W     : counter width (counters wrap)
//   MAX_INSTR : watchdog limit on retired instructions, 0 = disabled
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   start_i       : leave IDLE; step_mode_i selects single-step
//   step_i        : retire one instruction in STEP_WAIT
//   clear_i       : synchronous return to reset values
//   bus           : slave side of y86_pc_status_if (new_pc, flags in;
//                   pc, commit, status, one-hot status out)
//   running_o     : RUN or STEP_WAIT
//   wd_trip_o     : sticky watchdog trip
//   cycle_cnt_o   : clocks spent running
//   instr_cnt_o   : retired instructions
// ---------------------------------------------------------------------------
module y86_pc_status
    import y86_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                CNT_W     = 32,
    parameter int unsigned       MAX_INSTR = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                step_mode_i,
    input  logic                step_i,
    input  logic                clear_i,
    y86_pc_status_if.slave      bus,
    output logic                running_o,
    output logic                wd_trip_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);

    localparam logic             WD_EN    = (MAX_INSTR != 32'd0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_INSTR);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_e       state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [2:0]        status_q,    status_d;
    stat_onehot_t      onehot_q,    onehot_d;
    logic              wd_trip_q,   wd_trip_d;
    logic              running_q,   running_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

    logic              commit_s;
    logic              attempt_s;
    logic [CNT_W-1:0]  instr_inc_s;
    logic              exc_s;
    logic [2:0]        enc_status_s;
    stat_onehot_t      enc_onehot_s;

    y86_stat_enc u_stat_enc (
        .hlt_i     (bus.hlt),
        .in_mem_i  (bus.in_mem),
        .in_inst_i (bus.in_inst),
        .exc_o     (exc_s),
        .status_o  (enc_status_s),
        .onehot_o  (enc_onehot_s)
    );

    // A cycle that would retire an instruction; only then are flags looked at
    assign attempt_s   = (state_q == ST_RUN) || ((state_q == ST_STEP_WAIT) && step_i);
    assign instr_inc_s = instr_cnt_q + CNT_ONE;

    // Next-state, commit and datapath updates; clear and reset override all
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        status_d    = status_q;
        onehot_d    = onehot_q;
        wd_trip_d   = wd_trip_q;
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        commit_s    = 1'b0;

        // rst_n is included so nothing commits during the reset cycle
        if (clear_i || !rst_n) begin
            state_d     = ST_IDLE;
            pc_d        = RESET_PC;
            status_d    = STAT_AOK;
            onehot_d    = stat_decode(STAT_AOK);
            wd_trip_d   = 1'b0;
            instr_cnt_d = {CNT_W{1'b0}};
            cycle_cnt_d = {CNT_W{1'b0}};
            commit_s    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = step_mode_i ? ST_STEP_WAIT : ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN, ST_STEP_WAIT: begin
                    cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                    if (attempt_s) begin
                        if (exc_s) begin
                            // Faulting instruction does not retire; pc keeps its address
                            status_d = enc_status_s;
                            onehot_d = enc_onehot_s;
                            state_d  = ST_STOP;
                        end else begin
                            commit_s    = 1'b1;
                            pc_d        = bus.new_pc;
                            instr_cnt_d = instr_inc_s;
                            if (WD_EN && (instr_inc_s == WD_LIMIT)) begin
                                wd_trip_d = 1'b1;
                                state_d   = ST_STOP;
                            end else begin
                                state_d = state_q;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_STOP: begin
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign running_d = (state_d == ST_RUN) || (state_d == ST_STEP_WAIT);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            status_q    <= STAT_AOK;
            onehot_q    <= stat_decode(STAT_AOK);
            wd_trip_q   <= 1'b0;
            running_q   <= 1'b0;
            instr_cnt_q <= {CNT_W{1'b0}};
            cycle_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            status_q    <= status_d;
            onehot_q    <= onehot_d;
            wd_trip_q   <= wd_trip_d;
            running_q   <= running_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.commit  = commit_s;
    assign bus.status  = status_q;
    assign bus.aok     = onehot_q.aok;
    assign bus.halt    = onehot_q.halt;
    assign bus.adr     = onehot_q.adr;
    assign bus.ins     = onehot_q.ins;
    assign running_o   = running_q;
    assign wd_trip_o   = wd_trip_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_y86_pc_status.sv
// ---------------------------------------------------------------------------
// tb_y86_pc_status
// Directed bench for y86_pc_status. Three instances share the stimulus:
//   dut_a : defaults (64-bit PC, 32-bit counters, no watchdog)
//   dut_w : MAX_INSTR = 3
//   dut_c : CNT_W = 4 (counter wrap)
// new_pc is modelled as pc + stride, or a fixed value when fixed_mode = 1.
// ---------------------------------------------------------------------------
module tb_y86_pc_status;

    logic        clk;
    logic        rst_n;
    logic        start, step_mode, step, clear;
    logic        hlt, in_mem, in_inst;
    logic        fixed_mode;
    logic [63:0] fixed_pc;
    logic [63:0] stride;
    int          checks;
    int          failures;

    logic        run_a, wd_a, run_w, wd_w, run_c, wd_c;
    logic [31:0] cyc_a, ins_a, cyc_w, ins_w;
    logic [3:0]  cyc_c, ins_c;

    y86_pc_status_if #(.ADDR_W(64)) ifa ();
    y86_pc_status_if #(.ADDR_W(64)) ifw ();
    y86_pc_status_if #(.ADDR_W(64)) ifc ();

    assign ifa.new_pc  = fixed_mode ? fixed_pc : ifa.pc + stride;
    assign ifw.new_pc  = fixed_mode ? fixed_pc : ifw.pc + stride;
    assign ifc.new_pc  = fixed_mode ? fixed_pc : ifc.pc + stride;
    assign ifa.hlt     = hlt;
    assign ifw.hlt     = hlt;
    assign ifc.hlt     = hlt;
    assign ifa.in_mem  = in_mem;
    assign ifw.in_mem  = in_mem;
    assign ifc.in_mem  = in_mem;
    assign ifa.in_inst = in_inst;
    assign ifw.in_inst = in_inst;
    assign ifc.in_inst = in_inst;

    y86_pc_status dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .step_mode_i(step_mode),
        .step_i(step), .clear_i(clear), .bus(ifa), .running_o(run_a),
        .wd_trip_o(wd_a), .cycle_cnt_o(cyc_a), .instr_cnt_o(ins_a)
    );

    y86_pc_status #(.MAX_INSTR(32'd3)) dut_w (
        .clk(clk), .rst_n(rst_n), .start_i(start), .step_mode_i(step_mode),
        .step_i(step), .clear_i(clear), .bus(ifw), .running_o(run_w),
        .wd_trip_o(wd_w), .cycle_cnt_o(cyc_w), .instr_cnt_o(ins_w)
    );

    y86_pc_status #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start), .step_mode_i(step_mode),
        .step_i(step), .clear_i(clear), .bus(ifc), .running_o(run_c),
        .wd_trip_o(wd_c), .cycle_cnt_o(cyc_c), .instr_cnt_o(ins_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; clear = 1'b0;
        hlt = 1'b0; in_mem = 1'b0; in_inst = 1'b0;
        fixed_mode = 1'b0; fixed_pc = 64'd0; stride = 64'd10;

        // Reset state
        tick(); tick();
        rst_n = 1'b1; #1;
        check("rst_pc",      ifa.pc,               64'd0);
        check("rst_status",  64'(ifa.status),      64'd1);
        check("rst_aok",     64'(ifa.aok),         64'd1);
        check("rst_halt",    64'(ifa.halt),        64'd0);
        check("rst_commit",  64'(ifa.commit),      64'd0);
        check("rst_running", 64'(run_a),           64'd0);
        check("rst_wd",      64'(wd_a),            64'd0);
        check("rst_cycle",   64'(cyc_a),           64'd0);
        check("rst_instr",   64'(ins_a),           64'd0);

        // Free run, new_pc = pc + 10
        start = 1'b1; step_mode = 1'b0; #1;
        check("idle_commit", 64'(ifa.commit), 64'd0);
        tick(); start = 1'b0; #1;
        check("run_running", 64'(run_a), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("run_pc",     ifa.pc,          64'(10 * i));
            check("run_commit", 64'(ifa.commit), 64'd1);
            tick();
        end
        check("run_pc_end",   ifa.pc,          64'd50);
        check("run_instr",    64'(ins_a),      64'd5);
        check("run_status",   64'(ifa.status), 64'd1);
        clear = 1'b1; #1;
        check("clear_commit", 64'(ifa.commit), 64'd0);
        tick(); clear = 1'b0; #1;
        check("clear_pc",      ifa.pc,        64'd0);
        check("clear_running", 64'(run_a),    64'd0);
        check("clear_instr",   64'(ins_a),    64'd0);

        // Halt at pc = 0x20
        stride = 64'd16;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        check("pre_hlt_pc", ifa.pc, 64'h20);
        hlt = 1'b1; #1;
        check("hlt_commit", 64'(ifa.commit), 64'd0);
        tick(); hlt = 1'b0; #1;
        check("hlt_pc",      ifa.pc,          64'h20);
        check("hlt_status",  64'(ifa.status), 64'd2);
        check("hlt_halt",    64'(ifa.halt),   64'd1);
        check("hlt_aok",     64'(ifa.aok),    64'd0);
        check("hlt_running", 64'(run_a),      64'd0);
        check("hlt_instr",   64'(ins_a),      64'd2);
        check("hlt_cycle",   64'(cyc_a),      64'd3);
        start = 1'b1; tick(); start = 1'b0; #1;
        check("stop_start_running", 64'(run_a), 64'd0);
        check("stop_start_pc",      ifa.pc,     64'h20);

        // in_mem and in_inst together -> ADR
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        in_mem = 1'b1; in_inst = 1'b1; #1;
        check("adr_commit", 64'(ifa.commit), 64'd0);
        tick(); in_mem = 1'b0; in_inst = 1'b0; #1;
        check("adr_status", 64'(ifa.status), 64'd3);
        check("adr_adr",    64'(ifa.adr),    64'd1);
        check("adr_pc",     ifa.pc,          64'd0);

        // clear together with flags -> AOK
        clear = 1'b1; hlt = 1'b1; in_mem = 1'b1; tick();
        clear = 1'b0; hlt = 1'b0; in_mem = 1'b0; #1;
        check("clrflag_status",  64'(ifa.status), 64'd1);
        check("clrflag_aok",     64'(ifa.aok),    64'd1);
        check("clrflag_running", 64'(run_a),      64'd0);

        // All three flags -> HLT wins
        start = 1'b1; tick(); start = 1'b0;
        hlt = 1'b1; in_mem = 1'b1; in_inst = 1'b1; tick();
        hlt = 1'b0; in_mem = 1'b0; in_inst = 1'b0; #1;
        check("prio_status", 64'(ifa.status), 64'd2);

        // in_inst alone -> INS
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        in_inst = 1'b1; tick(); in_inst = 1'b0; #1;
        check("ins_status", 64'(ifa.status), 64'd4);
        check("ins_ins",    64'(ifa.ins),    64'd1);
        clear = 1'b1; tick(); clear = 1'b0;

        // Single-step: steps in cycles 3 and 7, hlt without step in cycle 5
        step_mode = 1'b1; start = 1'b1; tick(); start = 1'b0; step_mode = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            step = (c == 3) || (c == 7);
            hlt  = (c == 5);
            #1;
            check("step_commit", 64'(ifa.commit), 64'(step));
            check("step_pc",     ifa.pc, 64'(16 * (int'(c > 3) + int'(c > 7))));
            tick();
        end
        step = 1'b0; hlt = 1'b0; #1;
        check("step_pc_end",  ifa.pc,          64'h20);
        check("step_instr",   64'(ins_a),      64'd2);
        check("step_cycle",   64'(cyc_a),      64'd9);
        check("step_running", 64'(run_a),      64'd1);
        check("step_status",  64'(ifa.status), 64'd1);

        // Watchdog, MAX_INSTR = 3
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("wd_commit", 64'(ifw.commit), 64'd1);
            tick();
        end
        check("wd_trip",     64'(wd_w),       64'd1);
        check("wd_running",  64'(run_w),      64'd0);
        check("wd_status",   64'(ifw.status), 64'd1);
        check("wd_instr",    64'(ins_w),      64'd3);
        check("wd_pc",       ifw.pc,          64'h30);
        check("nowd_running", 64'(run_a),     64'd1);
        start = 1'b1; tick(); start = 1'b0; #1;
        check("wd_start_ignored", 64'(run_w), 64'd0);
        check("wd_sticky",        64'(wd_w),  64'd1);

        // Watchdog limit and exception in the same cycle
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        hlt = 1'b1; #1;
        check("wdexc_commit", 64'(ifw.commit), 64'd0);
        tick(); hlt = 1'b0; #1;
        check("wdexc_trip",   64'(wd_w),       64'd0);
        check("wdexc_status", 64'(ifw.status), 64'd2);
        check("wdexc_instr",  64'(ins_w),      64'd2);

        // Reset mid-run with new_pc = 0x100
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
        fixed_mode = 1'b1; fixed_pc = 64'h100; rst_n = 1'b0; #1;
        check("midrst_commit", 64'(ifa.commit), 64'd0);
        tick(); rst_n = 1'b1; fixed_mode = 1'b0; #1;
        check("midrst_pc",      ifa.pc,     64'd0);
        check("midrst_instr",   64'(ins_a), 64'd0);
        check("midrst_cycle",   64'(cyc_a), 64'd0);
        check("midrst_running", 64'(run_a), 64'd0);

        // 17 commits with 4-bit counters
        start = 1'b1; tick(); start = 1'b0;
        repeat (17) tick();
        check("wrap_instr",   64'(ins_c), 64'd1);
        check("wrap_cycle",   64'(cyc_c), 64'd1);
        check("wrap_pc",      ifc.pc,     64'h110);
        check("wrap_running", 64'(run_c), 64'd1);
        check("nowrap_instr", 64'(ins_a), 64'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
